// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: sequences one ADC capture burst (arm, optional level trigger, decimated writes, drain) into the data FIFO.
// Define AUTO_TRIG_EN to add a trigger timeout that forces capture and pulses auto_trig.
module adc_capture_ctrl #(
  parameter int CAP_WORDS  = 4096,
  parameter int FIFO_DEPTH = 8192,
  parameter int USEDW_W    = 13,
  parameter int DECIM_W    = 8
`ifdef AUTO_TRIG_EN
  , parameter int TIMEOUT_CYC = 1000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               trig_en,
  input  logic               trig_falling,
  input  logic [7:0]         trig_level,
  input  logic [DECIM_W-1:0] decim,
  input  logic [15:0]        adc_in,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  input  logic               fifo_wrempty,
  output logic               fifo_wr,
  output logic [15:0]        fifo_din,
  output logic               busy,
  output logic               done,
  output logic               overflow,
`ifdef AUTO_TRIG_EN
  output logic               auto_trig,
`endif
  output logic [2:0]         state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, WAIT_TRIG = 3'd2, CAPTURE = 3'd3, DRAIN = 3'd4} state_t;
  localparam int WC_W = $clog2(CAP_WORDS + 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(CAP_WORDS - 1);
  localparam logic [USEDW_W-1:0] FULL_LVL = USEDW_W'(FIFO_DEPTH - 2);
`ifdef AUTO_TRIG_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q;
`endif
  state_t             state_q;
  logic [WC_W-1:0]    word_cnt_q;
  logic [DECIM_W-1:0] decim_cnt_q, decim_q;
  logic [7:0]         prev_a_q;
  logic               drain_seen_q;
  logic               trig_hit, slot, full;
  assign trig_hit = trig_falling ? (prev_a_q >= trig_level && adc_in[7:0] < trig_level)
                                 : (prev_a_q < trig_level && adc_in[7:0] >= trig_level);
  // The triggering sample itself is written, so a trigger counts as a write slot.
  assign slot  = (state_q == CAPTURE && decim_cnt_q == '0) || (state_q == WAIT_TRIG && trig_hit);
  assign full  = fifo_wrusedw >= FULL_LVL;
  assign busy  = state_q != IDLE;
  assign state = state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      decim_cnt_q  <= '0;
      decim_q      <= '0;
      prev_a_q     <= '0;
      drain_seen_q <= 1'b0;
      fifo_wr      <= 1'b0;
      fifo_din     <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
`ifdef AUTO_TRIG_EN
      to_cnt_q     <= '0;
      auto_trig    <= 1'b0;
`endif
    end else begin
      fifo_wr <= 1'b0;
      done    <= 1'b0;
`ifdef AUTO_TRIG_EN
      auto_trig <= 1'b0;
`endif
      if (abort && state_q != IDLE) state_q <= IDLE;
      else if (slot && full) begin
        overflow     <= 1'b1;
        drain_seen_q <= 1'b0;
        state_q      <= DRAIN;
      end else if (slot) begin
        fifo_wr      <= 1'b1;
        fifo_din     <= adc_in;
        word_cnt_q   <= word_cnt_q + 1'b1;
        decim_cnt_q  <= (decim_q == '0) ? '0 : DECIM_W'(1);
        drain_seen_q <= 1'b0;
        state_q      <= (word_cnt_q == LAST_WORD) ? DRAIN : CAPTURE;
      end else
        case (state_q)
          IDLE: if (start && fifo_wrempty) state_q <= ARM;
          ARM: begin
            word_cnt_q  <= '0;
            decim_cnt_q <= '0;
            decim_q     <= decim;
            overflow    <= 1'b0;
            prev_a_q    <= adc_in[7:0];
`ifdef AUTO_TRIG_EN
            to_cnt_q    <= '0;
`endif
            state_q     <= trig_en ? WAIT_TRIG : CAPTURE;
          end
          WAIT_TRIG: begin
            prev_a_q <= adc_in[7:0];
`ifdef AUTO_TRIG_EN
            to_cnt_q <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) begin
              auto_trig <= 1'b1;
              state_q   <= CAPTURE;
            end
`endif
          end
          CAPTURE: decim_cnt_q <= (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + 1'b1;
          DRAIN: begin
            drain_seen_q <= 1'b1;
            if (drain_seen_q && fifo_wrempty) begin
              done    <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: randomized scoreboard bench; expected FIFO words come from a sample-sequence model of each burst.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;
  localparam int CAP = 16, DEPTH = 64, UW = 7, DW = 8, N = 320;
`ifdef AUTO_TRIG_EN
  localparam int TO = 100;
  logic auto_trig;
  int   n_auto = 0;
`endif
  logic          clk = 0, rst = 1, start = 0, abort = 0, trig_en = 0, trig_falling = 0;
  logic [7:0]    trig_level = 0;
  logic [DW-1:0] decim = 0;
  logic [15:0]   adc_in = 0;
  logic [UW-1:0] fifo_wrusedw;
  logic          fifo_wrempty, fifo_wr, busy, done, overflow;
  logic [15:0]   fifo_din;
  logic [2:0]    state;
  int            occ = 0, n_checks = 0, n_fails = 0, n_done = 0, drain_k = 0;
  bit            drain_en = 0, force_full = 0, exp_done = 0;
  logic [15:0]   exp_q[$];
  logic [15:0]   s[N];

  adc_capture_ctrl #(.CAP_WORDS(CAP), .FIFO_DEPTH(DEPTH), .USEDW_W(UW), .DECIM_W(DW)
`ifdef AUTO_TRIG_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trig_en(trig_en),
    .trig_falling(trig_falling), .trig_level(trig_level), .decim(decim), .adc_in(adc_in),
    .fifo_wrusedw(fifo_wrusedw), .fifo_wrempty(fifo_wrempty), .fifo_wr(fifo_wr),
    .fifo_din(fifo_din), .busy(busy), .done(done), .overflow(overflow),
`ifdef AUTO_TRIG_EN
    .auto_trig(auto_trig),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // FIFO occupancy model: writes from the DUT, reads whenever drain_en allows.
  always @(posedge clk or posedge rst)
    if (rst) occ <= 0;
    else occ <= occ + int'(fifo_wr) - int'(drain_en && occ != 0);
  assign fifo_wrempty = occ == 0;
  assign fifo_wrusedw = force_full ? UW'(DEPTH - 2) : UW'(occ);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "-state"}, state, 0);
    chk({tag, "-fifo_wr"}, fifo_wr, 0);
    chk({tag, "-fifo_din"}, fifo_din, 0);
    chk({tag, "-busy"}, busy, 0);
    chk({tag, "-done"}, done, 0);
    chk({tag, "-overflow"}, overflow, 0);
  endtask

  // Monitor: pops the scoreboard on every write and checks done timing against the drain rule.
  always @(negedge clk)
    if (rst) begin
      drain_k  = 0;
      exp_done = 0;
    end else begin
      if (exp_done || done) chk("done-timing", done, exp_done);
      if (done) n_done++;
`ifdef AUTO_TRIG_EN
      if (auto_trig) n_auto++;
`endif
      if (fifo_wr) begin
        if (exp_q.size() == 0) chk("unexpected-write", fifo_din, 16'hxxxx);
        else chk("write-data", fifo_din, exp_q.pop_front());
      end
      drain_k  = (state == 3'd4) ? drain_k + 1 : 0;
      exp_done = state == 3'd4 && drain_k >= 2 && fifo_wrempty && !abort;
    end

  // mode: 0 normal, 1 FIFO forced full at slot k, 2 abort at slot k, 3 async reset at slot k.
  // pattern: 0 random, 1 rising ramp, 2 falling ramp, 3 flat.
  task automatic burst(input bit te, input bit tf, input logic [7:0] lvl, input int d,
                       input int mode, input int k, input int pattern);
    int t, cut, last, ndone0;
    bit found;
    drain_en = 1;
    for (int i = 0; i < 500 && !fifo_wrempty; i++) begin
      @(posedge clk);
      #1;
    end
    chk("empty-before-start", fifo_wrempty, 1);
    do begin
      for (int i = 0; i < N; i++) begin
        s[i] = 16'($urandom);
        if (pattern == 1) s[i][7:0] = 8'(i < 34 ? 'h6F + i : 'h90);
        if (pattern == 2) s[i][7:0] = 8'(i < 34 ? 'h91 - i : 'h70);
        if (pattern == 3) s[i][7:0] = 8'h20;
      end
      t = 2;
      found = !te;
      for (int i = 2; i < 60 && !found; i++)
        if (tf ? (s[i-1][7:0] >= lvl && s[i][7:0] < lvl) : (s[i-1][7:0] < lvl && s[i][7:0] >= lvl)) begin
          t = i;
          found = 1;
        end
`ifdef AUTO_TRIG_EN
      if (!found && pattern == 3) begin
        t = 2 + TO;
        found = 1;
      end
`endif
    end while (!found);
    last = t + (CAP - 1) * (d + 1);
    cut  = (mode == 0) ? N : t + k * (d + 1);
    for (int j = 0; j < CAP; j++)
      if (t + j * (d + 1) < cut) exp_q.push_back(s[t + j * (d + 1)]);
    trig_en = te;
    trig_falling = tf;
    trig_level = lvl;
    decim = DW'(d);
    ndone0 = n_done;
    for (int i = 0; i < N; i++) begin
      @(posedge clk);
      #1;
      adc_in = s[i];
      start = (i == 0) || (i > 2 && i <= last && i <= cut && $urandom_range(0, 5) == 0) || (mode == 2 && i == cut);
      abort = (mode == 2 && i == cut);
      force_full = (mode == 1 && i >= cut);
      drain_en = (mode == 2) ? 1'b0 : 1'($urandom);
      if (i == 2) decim = DW'($urandom);
      if (mode == 3 && i == cut) begin
        #2 rst = 1;
        #1 reset_chk("async-rst");
        exp_q.delete();
        @(negedge clk);
        #1 rst = 0;
      end
      if (mode == 2 && i == cut + 1) begin
        @(negedge clk);
        chk("abort-state", state, 0);
        chk("abort-busy", busy, 0);
        chk("abort-fifo_wr", fifo_wr, 0);
      end
    end
    start = 0;
    abort = 0;
    force_full = 0;
    chk("words-outstanding", exp_q.size(), 0);
    exp_q.delete();
    chk("done-count", n_done - ndone0, (mode < 2) ? 1 : 0);
    chk("idle-after-burst", state, 0);
    if (mode < 3) chk("overflow-flag", overflow, (mode == 1) ? 1 : 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_chk("reset");
    @(negedge clk);
    #1 rst = 0;
    burst(0, 0, 8'h00, 0, 0, 0, 0);
    burst(1, 0, 8'h80, 0, 0, 0, 1);
    burst(1, 1, 8'h80, 0, 0, 0, 2);
    burst(0, 0, 8'h00, 3, 0, 0, 0);
    repeat (6) burst(1, 1'($urandom), 8'($urandom_range(16, 240)), $urandom_range(0, 3), 0, 0, 0);
    burst(0, 0, 8'h00, $urandom_range(0, 2), 1, 7, 0);
    burst(0, 0, 8'h00, 0, 2, 5, 0);
    chk("fifo-nonempty-after-abort", fifo_wrempty, 0);
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("start-ignored-nonempty", state, 0);
    burst(1, 0, 8'h80, 1, 3, 6, 1);
`ifdef AUTO_TRIG_EN
    begin
      int a0;
      a0 = n_auto;
      burst(1, 0, 8'h80, 0, 0, 0, 3);
      chk("auto-trig-pulses", n_auto - a0, 1);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences one ADC capture burst into the ADC data FIFO.
- Runs on sys_clk, between the merged ADC output (16-bit, two 8-bit samples) and the FIFO write port.
- On start it arms, waits for an optional level trigger on sample A, then writes a fixed number of words with optional decimation.
- It then waits for the UART side to drain the FIFO before signalling done.

Parameters:
CAP_WORDS, 4096, words written per capture burst (>=2)
FIFO_DEPTH, 8192, FIFO capacity in words
USEDW_W, 13, width of fifo_wrusedw
DECIM_W, 8, width of decimation ratio input
TIMEOUT_CYC, 1000000, auto-trigger timeout in clk cycles (AUTO_TRIG_EN only)

Ports:
clk  in  1  sys_clk, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle capture request
abort  in  1  single-cycle abort, highest priority
trig_en  in  1  1 = wait for trigger, 0 = capture immediately
trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
trig_level  in  8  unsigned trigger threshold on adc_in[7:0]
decim  in  DECIM_W  write one word every decim+1 cycles (0 = every cycle)
adc_in  in  16  merged ADC word
fifo_wrusedw  in  USEDW_W  FIFO fill level, write side
fifo_wrempty  in  1  FIFO empty, write side
fifo_wr  out  1  FIFO write request
fifo_din  out  16  FIFO write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a burst has fully drained
overflow  out  1  sticky; set when a write is suppressed because the FIFO is full
state  out  3  current state encoding, for debug

Behaviour:
- Reset values: state=IDLE(0), fifo_wr=0, fifo_din=0, busy=0, done=0, overflow=0; all counters 0.
- States: IDLE=0, ARM=1, WAIT_TRIG=2, CAPTURE=3, DRAIN=4.
- IDLE:
  - start=1 and fifo_wrempty=1 -> ARM.
  - start while the FIFO is non-empty is ignored.
- ARM (1 cycle):
  - word_cnt=0, decim_cnt=0, overflow cleared, prev_a loaded with adc_in[7:0].
  - -> WAIT_TRIG if trig_en=1, else -> CAPTURE.
- WAIT_TRIG:
  - prev_a <= adc_in[7:0] every cycle.
  - Rising trigger: prev_a < trig_level and adc_in[7:0] >= trig_level.
  - Falling trigger: prev_a >= trig_level and adc_in[7:0] < trig_level.
  - On trigger -> CAPTURE. The triggering sample is the first word written.
- CAPTURE:
  - decim_cnt counts 0..decim. A write slot occurs when decim_cnt==0.
  - At a write slot: fifo_din <= adc_in, fifo_wr <= 1 on the next cycle (registered, 1-cycle latency); word_cnt increments.
  - Outside write slots fifo_wr <= 0.
  - A write is suppressed when fifo_wrusedw >= FIFO_DEPTH-2. Then overflow <= 1 and the state goes -> DRAIN.
  - The write with word_cnt==CAP_WORDS-1 is the last one -> DRAIN. Exactly CAP_WORDS fifo_wr pulses per normal burst.
- DRAIN:
  - fifo_wr=0.
  - Wait for fifo_wrempty=1 sampled on at least the 2nd DRAIN cycle, which covers FIFO flag latency.
  - Then done=1 for one cycle -> IDLE.
- abort in any non-IDLE state -> IDLE next cycle. fifo_wr=0 from that edge, no done pulse, overflow retained.
- start while busy is ignored. abort and start in the same cycle: abort wins.
- decim changes are sampled only in ARM. The latched copy is used for the whole burst.
- Counter widths: word_cnt is clog2(CAP_WORDS+1) bits; decim_cnt is DECIM_W bits. No wrap inside a burst.

Optional Feature:
- Macro: AUTO_TRIG_EN.
- Defined:
  - A timeout counter runs in WAIT_TRIG.
  - After TIMEOUT_CYC cycles without a trigger -> CAPTURE (forced trigger) and a 1-cycle output pulse auto_trig=1.
  - The counter clears on entry to WAIT_TRIG.
- Undefined:
  - WAIT_TRIG waits indefinitely.
  - The auto_trig port and the counter are absent.

Test Plan:
- trig_en=0, decim=0, CAP_WORDS=16, start with FIFO empty -> ARM then CAPTURE; exactly 16 consecutive fifo_wr pulses; fifo_din equals adc_in delayed 1 cycle; done pulse 1 cycle after fifo_wrempty=1 in DRAIN.
- trig_en=1, trig_level=0x80, adc_in[7:0] ramp 0x70..0x90 step 1 -> first fifo_din[7:0]=0x80; trig_falling=1 on a descending ramp -> first word 0x7F.
- decim=3, CAP_WORDS=8 -> fifo_wr high every 4th cycle; 8 pulses total; burst spans 29 cycles from first write.
- fifo_wrusedw forced to FIFO_DEPTH-2 mid-capture -> no further writes; overflow=1 sticky; DRAIN entered; done after empty.
- abort in CAPTURE after 5 writes -> fifo_wr=0 next cycle; state=IDLE; busy=0; no done. start with fifo_wrempty=0 -> stays IDLE.
- rst asserted mid-CAPTURE -> all outputs return to reset values immediately (asynchronous). AUTO_TRIG_EN with TIMEOUT_CYC=100 and flat input -> capture starts 100 cycles after WAIT_TRIG entry; auto_trig pulses once.
